vlc_manchester_tx: RTL
======================

VLC_MANCHESTER_TX -- requirements
Module: vlc_manchester_tx

Interface
REQ-001 Parameter CLKS_PER_HALF, default 50, clk cycles per Manchester half-bit; legal range 2..65535.
REQ-002 Parameter PREAMBLE, default 8'hAA, 8-bit preamble sent MSB first before every word.
REQ-003 Parameter GAP_HALFBITS, default 4, number of idle half-bits (LED low) after each frame; legal range 0..255.
REQ-004 clk  input  1  single clock; all logic is on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  permits starting a new frame.
REQ-007 word_avail  input  1  upstream 32-bit word buffer holds unread data.
REQ-008 word_in  input  32  upstream buffer output word; valid one cycle after the pop sample edge.
REQ-009 pop  output  1  single-cycle read strobe to the upstream buffer.
REQ-010 led_out  output  1  Manchester-encoded LED drive.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 words_sent  output  16  count of completed frames; wraps 16'hFFFF -> 0.

Function
REQ-013 The FSM SHALL use the states IDLE, POP, LOAD, PREAMBLE, DATA and GAP.
REQ-014 IDLE: when enable=1 and word_avail=1 are sampled, the block SHALL go to POP.
REQ-015 POP: pop SHALL be high for exactly one cycle, then the block SHALL go to LOAD.
REQ-016 pop SHALL be asserted only from POP and never while word_avail=0 was sampled.
REQ-017 LOAD: the block SHALL latch word_in into the 32-bit shift register and go to PREAMBLE.
REQ-018 The latched word SHALL be used because upstream registers its output on the pop edge.
REQ-019 PREAMBLE: the block SHALL send the 8 PREAMBLE bits MSB first, then go to DATA.
REQ-020 DATA: the block SHALL send 32 bits in byte order word[7:0], [15:8], [23:16], [31:24], each byte MSB first.
REQ-021 This bit order SHALL preserve the upstream arrival order, because upstream packs the first-received byte into bits [7:0].
REQ-022 Manchester encoding SHALL be IEEE 802.3: bit 1 = low then high; bit 0 = high then low.
REQ-023 Each half-bit SHALL last exactly CLKS_PER_HALF cycles.
REQ-024 A half-bit counter SHALL reload to 0 at each half-bit boundary.
REQ-025 The bit counter SHALL be 6 bits wide and count 0..39 across the preamble and data bits.
REQ-026 led_out SHALL be registered and SHALL change only on half-bit boundaries.
REQ-027 Frame length SHALL be 80*CLKS_PER_HALF cycles from the first PREAMBLE cycle to the last DATA cycle.
REQ-028 At the end of DATA, words_sent SHALL increment by 1 and the block SHALL go to GAP.
REQ-029 GAP: led_out SHALL be 0 for GAP_HALFBITS*CLKS_PER_HALF cycles, then the block SHALL go to IDLE.
REQ-030 If GAP_HALFBITS=0, the block SHALL skip GAP and go directly to IDLE.
REQ-031 led_out SHALL be 0 in IDLE, POP, LOAD and GAP.
REQ-032 A frame in progress SHALL always complete, even if enable drops or word_avail changes.
REQ-033 enable SHALL be checked only in IDLE.
REQ-034 With word_avail held high, back-to-back frames SHALL be separated by the GAP time plus 3 cycles (IDLE, POP, LOAD).
REQ-035 word_avail falling in the same cycle as the IDLE->POP decision SHALL NOT cancel the pop, since the decision was already sampled.
REQ-036 Latency from word_avail=1 sampled in IDLE to the first PREAMBLE half-bit SHALL be 3 cycles.

Reset
REQ-037 On rst_n=0, regardless of clk, the block SHALL force state=IDLE, pop=0, led_out=0, busy=0 and words_sent=0.
REQ-038 On rst_n=0, the block SHALL clear the shift register and all counters.
REQ-039 Reset mid-frame SHALL abort the frame immediately, with led_out=0 in the same cycle.
REQ-040 The aborted frame SHALL not be counted, and no pop SHALL be re-issued for it.
REQ-041 After rst_n rises, the block SHALL take no action until the first clk edge that samples IDLE conditions.

Verification
REQ-042 The bench SHALL cover these directed scenarios, all with CLKS_PER_HALF=4 and GAP_HALFBITS=2:
- Single word 32'h000000A5 with enable=1 -> one pop pulse; led_out = preamble 10101010 then bits 10100101 then 24 zero bits; each bit spans 8 cycles; words_sent=1; busy falls 8 gap cycles after DATA ends.
- Byte order, word 32'h04030201 -> data bytes transmitted in the order 01, 02, 03, 04, each byte MSB first.
- Back-to-back, word_avail held high for 2 words -> exactly 2 pop pulses; second PREAMBLE starts 11 cycles after the first DATA ends; words_sent=2.
- enable dropped at the 5th data bit -> current frame completes; no further pop while enable=0; resumes after enable=1.
- rst_n pulsed low at the 20th data bit -> led_out=0 and busy=0 asynchronously; words_sent=0; no pop until the next IDLE start.
- Counter wrap, words_sent preloaded via a 65535-frame run or a forced value -> next frame yields words_sent=0.

Source files
------------

// File: rtl/vlc_manchester_tx.sv
// Manchester (IEEE 802.3) LED transmitter for visible-light links: pops one
// 32-bit word from upstream, sends preamble + word, then idles for a gap.
module vlc_manchester_tx #(
  parameter int unsigned CLKS_PER_HALF = 50,
  parameter logic [7:0]  PREAMBLE      = 8'hAA,
  parameter int unsigned GAP_HALFBITS  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        word_avail,
  input  logic [31:0] word_in,
  output logic        pop,
  output logic        led_out,
  output logic        busy,
  output logic [15:0] words_sent
);

  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_HALF - 1);
  localparam logic [7:0]  GAP_LAST  = (GAP_HALFBITS > 0) ? 8'(GAP_HALFBITS - 1) : 8'd0;
  localparam logic [5:0]  PRE_LAST  = 6'd7;
  localparam logic [5:0]  BIT_LAST  = 6'd39;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_LOAD,
    ST_PREAMBLE,
    ST_DATA,
    ST_GAP
  } state_t;

  state_t      state;
  state_t      stateNext;
  logic [15:0] halfCnt;
  logic        halfSel;
  logic [5:0]  bitCnt;
  logic [7:0]  gapCnt;
  logic [31:0] shiftReg;
  logic [15:0] sentCnt;

  logic        halfEnd;
  logic        bitEnd;
  logic [2:0]  preIdx;
  logic [2:0]  preNextIdx;
  logic        curBit;
  logic        nextBit;

  assign words_sent = sentCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    pop       = 1'b0;
    busy      = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (enable && word_avail) stateNext = ST_POP;
      end
      ST_POP: begin
        pop       = 1'b1;
        stateNext = ST_LOAD;
      end
      ST_LOAD:     stateNext = ST_PREAMBLE;
      ST_PREAMBLE: if (bitEnd && (bitCnt == PRE_LAST)) stateNext = ST_DATA;
      ST_DATA: begin
        if (bitEnd && (bitCnt == BIT_LAST))
          stateNext = (GAP_HALFBITS == 0) ? ST_IDLE : ST_GAP;
      end
      ST_GAP:      if (halfEnd && (gapCnt == GAP_LAST)) stateNext = ST_IDLE;
      default:     stateNext = ST_IDLE;
    endcase
  end

  // nextBit is the bit following the current one, so its first half can be
  // registered onto led_out at the same edge that closes the current bit.
  always_comb begin
    halfEnd    = (halfCnt == HALF_LAST);
    bitEnd     = halfEnd && halfSel;
    preIdx     = 3'd7 - bitCnt[2:0];
    preNextIdx = 3'd6 - bitCnt[2:0];
    curBit     = shiftReg[31];
    nextBit    = shiftReg[30];
    if (state == ST_PREAMBLE) begin
      curBit  = PREAMBLE[preIdx];
      nextBit = (bitCnt == PRE_LAST) ? shiftReg[31] : PREAMBLE[preNextIdx];
    end
  end

  // Bytes are reordered at load so a plain MSB-first shift emits [7:0] first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halfCnt  <= '0;
      halfSel  <= 1'b0;
      bitCnt   <= '0;
      gapCnt   <= '0;
      shiftReg <= '0;
      sentCnt  <= '0;
      led_out  <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          shiftReg <= {word_in[7:0], word_in[15:8], word_in[23:16], word_in[31:24]};
          halfCnt  <= '0;
          halfSel  <= 1'b0;
          bitCnt   <= '0;
          led_out  <= ~PREAMBLE[7];
        end
        ST_PREAMBLE, ST_DATA: begin
          if (!halfEnd) begin
            halfCnt <= halfCnt + 16'd1;
          end else begin
            halfCnt <= '0;
            if (!halfSel) begin
              halfSel <= 1'b1;
              led_out <= curBit;
            end else begin
              halfSel <= 1'b0;
              if (state == ST_DATA) shiftReg <= {shiftReg[30:0], 1'b0};
              if ((state == ST_DATA) && (bitCnt == BIT_LAST)) begin
                bitCnt  <= '0;
                gapCnt  <= '0;
                led_out <= 1'b0;
                sentCnt <= sentCnt + 16'd1;
              end else begin
                bitCnt  <= bitCnt + 6'd1;
                led_out <= ~nextBit;
              end
            end
          end
        end
        ST_GAP: begin
          led_out <= 1'b0;
          if (halfEnd) begin
            halfCnt <= '0;
            gapCnt  <= gapCnt + 8'd1;
          end else begin
            halfCnt <= halfCnt + 16'd1;
          end
        end
        default: begin
          led_out <= 1'b0;
          halfCnt <= '0;
        end
      endcase
    end
  end

endmodule
